// File: rtl/sdc_sector_server_if.sv
// Sector-transfer bus between the nanomig core, the sector server and the
// byte-wide image memory. The server side uses the slave modport.
interface sdc_sector_server_if;
  logic [7:0]  sdc_rd;
  logic [7:0]  sdc_wr;
  logic [31:0] sdc_sector;
  logic        sdc_busy;
  logic        sdc_done;
  logic        sdc_byte_in_strobe;
  logic [8:0]  sdc_byte_addr;
  logic [7:0]  sdc_byte_in_data;
  logic [7:0]  sdc_byte_out_data;
  logic [31:0] img_addr;
  logic        img_rd;
  logic        img_wr;
  logic [7:0]  img_wdata;
  logic [7:0]  img_rdata;
  logic        img_ready;

  // Handshake: img_rd/img_wr act as valid and img_ready as ready. A request
  // stays high with img_addr/img_wdata frozen until the clock edge that sees
  // img_ready; img_rdata is taken on that same edge. Reset may drop a pending
  // request without waiting for img_ready.
  modport slave (
    input  sdc_rd, sdc_wr, sdc_sector, sdc_byte_out_data, img_rdata, img_ready,
    output sdc_busy, sdc_done, sdc_byte_in_strobe, sdc_byte_addr,
           sdc_byte_in_data, img_addr, img_rd, img_wr, img_wdata
  );

  modport master (
    output sdc_rd, sdc_wr, sdc_sector, sdc_byte_out_data, img_rdata, img_ready,
    input  sdc_busy, sdc_done, sdc_byte_in_strobe, sdc_byte_addr,
           sdc_byte_in_data, img_addr, img_rd, img_wr, img_wdata
  );
endinterface

// File: rtl/sdc_sector_server.sv
// Sector server standing in for the SD card model: serves one 512-byte sector
// per request for eight drives out of a byte-wide image memory.
module sdc_sector_server #(
  parameter int IMG_BITS = 24,
  parameter int BYTE_GAP = 2,
  parameter int WR_LAT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  sdc_sector_server_if.slave bus,
  output logic [2:0]         dbg_state
);
  localparam int SEC_BITS = IMG_BITS - 9;
  localparam int ADDR_W   = IMG_BITS + 3;
  // The strobe cycle itself plus the following RD_REQ cycle already count
  // toward the gap, so RD_GAP only has to add what is left beyond two.
  localparam logic [15:0] GAP_LAST = 16'((BYTE_GAP > 2) ? BYTE_GAP - 2 : 0);
  localparam logic [15:0] LAT_LAST = 16'(WR_LAT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_GAP  = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_MEM  = 3'd4,
    S_DONE    = 3'd5,
    S_RELEASE = 3'd6
  } state_t;

  state_t state, state_d;

  logic [7:0]          req;
  logic [2:0]          sel_drv;
  logic                sel_rd;
  logic [2:0]          drv_q;
  logic [SEC_BITS-1:0] sec_q;
  logic                oor_q;
  logic [8:0]          n_q;
  logic [15:0]         gap_cnt;
  logic [15:0]         lat_cnt;
  logic [8:0]          byte_addr_q;
  logic [7:0]          in_data_q;
  logic                strobe_q;
  logic [7:0]          wdata_q;
  logic [ADDR_W-1:0]   addr_full;
  logic                mem_ready;

  logic accept, rd_take, wr_sample, advance;
  logic busy, done, img_rd, img_wr;

  assign req = bus.sdc_rd | bus.sdc_wr;

  // Lowest requesting drive wins; a read beats a write on that same drive.
  always_comb begin
    sel_drv = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) sel_drv = 3'(i);
    end
  end
  assign sel_rd = bus.sdc_rd[sel_drv];

  // Out-of-range sectors complete with normal timing but never touch memory.
  assign mem_ready = oor_q | bus.img_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    rd_take   = 1'b0;
    wr_sample = 1'b0;
    advance   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    img_rd    = 1'b0;
    img_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req != 8'h00) begin
          accept  = 1'b1;
          state_d = sel_rd ? S_RD_REQ : S_WR_ADDR;
        end
      end
      S_RD_REQ: begin
        busy   = 1'b1;
        img_rd = ~oor_q;
        if (mem_ready) begin
          rd_take = 1'b1;
          state_d = S_RD_GAP;
        end
      end
      S_RD_GAP: begin
        busy = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          if (n_q == 9'd511) state_d = S_DONE;
          else begin
            advance = 1'b1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_ADDR: begin
        // The core's byte is valid WR_LAT clocks after the address appears;
        // it is captured at the end of that cycle.
        busy = 1'b1;
        if (lat_cnt == LAT_LAST) begin
          wr_sample = 1'b1;
          state_d   = S_WR_MEM;
        end
      end
      S_WR_MEM: begin
        busy   = 1'b1;
        img_wr = ~oor_q;
        if (mem_ready) begin
          if (n_q == 9'd511) state_d = S_DONE;
          else begin
            advance = 1'b1;
            state_d = S_WR_ADDR;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (req == 8'h00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drv_q       <= '0;
      sec_q       <= '0;
      oor_q       <= 1'b0;
      n_q         <= '0;
      gap_cnt     <= '0;
      lat_cnt     <= '0;
      byte_addr_q <= '0;
      in_data_q   <= '0;
      strobe_q    <= 1'b0;
      wdata_q     <= '0;
    end else begin
      strobe_q <= rd_take;
      if (state == S_RD_GAP)  gap_cnt <= gap_cnt + 16'd1;
      if (state == S_WR_ADDR) lat_cnt <= lat_cnt + 16'd1;
      if (accept) begin
        drv_q       <= sel_drv;
        sec_q       <= bus.sdc_sector[SEC_BITS-1:0];
        oor_q       <= |bus.sdc_sector[31:SEC_BITS];
        n_q         <= '0;
        byte_addr_q <= '0;
        lat_cnt     <= '0;
      end
      if (rd_take) begin
        in_data_q   <= oor_q ? 8'h00 : bus.img_rdata;
        byte_addr_q <= n_q;
        gap_cnt     <= '0;
      end
      if (wr_sample) wdata_q <= bus.sdc_byte_out_data;
      if (advance) begin
        n_q     <= n_q + 9'd1;
        lat_cnt <= '0;
        if (state == S_WR_MEM) byte_addr_q <= n_q + 9'd1;
      end
    end
  end

  assign addr_full = {drv_q, sec_q, n_q};

  assign bus.img_addr           = 32'(addr_full);
  assign bus.img_rd             = img_rd;
  assign bus.img_wr             = img_wr;
  assign bus.img_wdata          = wdata_q;
  assign bus.sdc_busy           = busy;
  assign bus.sdc_done           = done;
  assign bus.sdc_byte_in_strobe = strobe_q;
  assign bus.sdc_byte_addr      = byte_addr_q;
  assign bus.sdc_byte_in_data   = in_data_q;
  assign dbg_state              = state;
endmodule
